// File: rtl/id_operand_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_operand_stage: IF/ID register, N-source priority bypass, load-use     |
// | hazard request, branch delay-slot tracking and stall cycle counter.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int AW      = 5,
  parameter int NFWD    = 3,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [STALL_W-1:0]            stall,
  input  logic                          flush,
  input  logic                          if_valid,
  input  logic [31:0]                   if_pc,
  input  logic [31:0]                   if_inst,
  output logic [AW-1:0]                 rf_raddr1,
  output logic [AW-1:0]                 rf_raddr2,
  input  logic [DATA_W-1:0]             rf_rdata1,
  input  logic [DATA_W-1:0]             rf_rdata2,
  input  logic [NFWD*(1+AW+DATA_W)-1:0] fwd_bus,
  input  logic [NFWD-1:0]               fwd_is_load,
  output logic                          id_valid,
  output logic [31:0]                   id_pc,
  output logic [31:0]                   id_inst,
  output logic [DATA_W-1:0]             opnd1,
  output logic [DATA_W-1:0]             opnd2,
  output logic                          stallreq,
  output logic                          in_delayslot,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int         SRC_W      = 1 + AW + DATA_W;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_BR_LO   = 6'b000010;
  localparam logic [5:0] OP_BR_HI   = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic [5:0]        opcode;
  logic [5:0]        func;
  logic              is_br;
  logic              ds_pend;
  logic              load1;
  logic              load2;
  logic [NFWD-1:0]   src_we;
  logic [AW-1:0]     src_addr [NFWD];
  logic [DATA_W-1:0] src_data [NFWD];
  logic              unused_bits;

  assign rs        = AW'(id_inst[25:21]);
  assign rt        = AW'(id_inst[20:16]);
  assign opcode    = id_inst[31:26];
  assign func      = id_inst[5:0];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  assign unused_bits = ^{stall[0], stall[STALL_W-1:3], id_inst[15:6]};

  generate
    for (genvar i = 0; i < NFWD; i++) begin : g_src
      assign src_data[i] = fwd_bus[i*SRC_W +: DATA_W];
      assign src_addr[i] = fwd_bus[i*SRC_W + DATA_W +: AW];
      assign src_we[i]   = fwd_bus[i*SRC_W + DATA_W + AW];
    end
  endgenerate

  // Scan from lowest priority upward so the youngest matching source wins last.
  always_comb begin
    opnd1 = rf_rdata1;
    opnd2 = rf_rdata2;
    load1 = 1'b0;
    load2 = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (src_we[i] && (src_addr[i] == rs)) begin
        opnd1 = src_data[i];
        load1 = fwd_is_load[i];
      end
      if (src_we[i] && (src_addr[i] == rt)) begin
        opnd2 = src_data[i];
        load2 = fwd_is_load[i];
      end
    end
    if (!id_valid || (rs == '0)) begin
      opnd1 = '0;
      load1 = 1'b0;
    end
    if (!id_valid || (rt == '0)) begin
      opnd2 = '0;
      load2 = 1'b0;
    end
  end

  assign stallreq = id_valid & (load1 | load2);

  assign is_br = (opcode == OP_REGIMM)
              || ((opcode >= OP_BR_LO) && (opcode <= OP_BR_HI))
              || ((opcode == OP_SPECIAL) && ((func == FN_JR) || (func == FN_JALR)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (flush || (stall[1] && !stall[2])) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= '0;
    end else if (!stall[1]) begin
      id_valid <= if_valid;
      id_pc    <= if_pc;
      id_inst  <= if_inst;
    end
  end

  // Only a real instruction leaving ID updates the slot flag; bubbles leave it pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ds_pend <= 1'b0;
    end else if (flush) begin
      ds_pend <= 1'b0;
    end else if (id_valid && !stall[2]) begin
      ds_pend <= is_br;
    end
  end

  assign in_delayslot = ds_pend & id_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stallreq && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/id_operand_stage.md
# id_operand_stage

Parametrised decode-side pipeline stage that sits between IF and EX. It holds the IF/ID register with stall, bubble and flush control, and fetches both source operands through an N-source priority bypass network. It detects load-use hazards and raises `stallreq`. It also tracks branch delay slots and counts stall cycles. It supersedes the fixed two-source bypass used in the current decode stage.

## Interface
Parameters:
- `DATA_W`, 32: register and data width.
- `AW`, 5: register address width.
- `NFWD`, 3: number of bypass sources. Index 0 has the highest priority (youngest stage).
- `STALL_W`, 6: stall bus width. Bit 1 is IF/ID, bit 2 is ID/EX.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stall`  in  STALL_W  stall vector from the stall controller.
- `flush`  in  1  squashes the IF/ID register and the delay-slot state.
- `if_valid`  in  1  IF output is a real instruction.
- `if_pc`  in  32  IF program counter.
- `if_inst`  in  32  fetched instruction word.
- `rf_raddr1` / `rf_raddr2`  out  AW  regfile read addresses. They are the rs/rt fields of `id_inst`.
- `rf_rdata1` / `rf_rdata2`  in  DATA_W  regfile read data, same cycle.
- `fwd_bus`  in  NFWD*(1+AW+DATA_W)  flattened `{we, waddr, wdata}` per source. Source 0 occupies the least-significant slice.
- `fwd_is_load`  in  NFWD  the source's `wdata` is not valid yet (load in flight).
- `id_valid`, `id_pc`, `id_inst`  out  1/32/32  registered stage contents.
- `opnd1` / `opnd2`  out  DATA_W  resolved rs/rt operands.
- `stallreq`  out  1  load-use hazard request.
- `in_delayslot`  out  1  the current ID instruction is a delay slot.
- `stall_cnt`  out  CNT_W  saturating count of `stallreq` cycles.

## Operation
IF/ID register. Conditions are evaluated in this priority order:
- `rst`==0: register becomes `{0, 0, 0}`.
- `flush`==1: register becomes `{0, 0, 0}`.
- `stall[1]`==1 and `stall[2]`==0: a bubble `{0, 0, 0}` is loaded.
- `stall[1]`==0: `{if_valid, if_pc, if_inst}` is loaded.
- Otherwise the register holds.

Operand resolution (combinational), for each of rs and rt:
- If `id_valid`==0 or the address is 0, the operand is 0.
- Otherwise take the lowest-index source with `we`==1 and `waddr`==addr, and use its `wdata`.
- If no source matches, use `rf_rdata`.
- Lower-priority matches are ignored even when they hold different data.

Load-use hazard:
- `stallreq` = `id_valid` & (rs hit or rt hit), where a hit means the winning source for that field has `fwd_is_load`==1.
- Both fields are compared for every instruction. This is conservative: no use-mask is applied.
- A load that is shadowed by a higher-priority non-load match does not stall.
- While `stallreq`==1, the operand outputs still follow the resolution rules, but EX must not consume them.

Branch detect (`is_br`, internal):
- opcode 000001.
- opcode 000010–000111.
- opcode 000000 with func 001000 or 001001.

Delay-slot state, register `ds_pend`:
- Reset value 0. `flush` sets it to 0.
- When `id_valid`==1 and `stall[2]`==0, `ds_pend` <= `is_br`.
- Otherwise it holds. Bubbles therefore do not consume a pending slot.
- `in_delayslot` = `ds_pend` & `id_valid`.

Stall counter:
- Reset value 0.
- Increments by 1 in each cycle where `stallreq`==1.
- Saturates at 2^CNT_W−1.
- `flush` does not clear it.

## Timing
- Reset values: `id_valid`=0, `id_pc`=0, `id_inst`=0, `opnd1`=0, `opnd2`=0, `stallreq`=0, `in_delayslot`=0, `stall_cnt`=0.
- IF to ID latency is one cycle. Operands, `stallreq` and regfile addresses are valid in the same cycle as `id_*`.
- `stallreq` is combinational. The controller is expected to return `stall[1]`=`stall[2]`=1 in that same cycle.
- `stall[2]`=0 with `stall[1]`=1 is a legal combination and inserts a bubble.
- Simultaneous `flush` and stall: flush wins.
- Simultaneous `rst`=0 and `flush`: reset wins.
- Reset asserted mid-stall clears all state at the next edge.
- A counter at its maximum value with `stallreq`=1 holds at the maximum.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `if_valid`=1 → every output is 0. Release reset with `if_pc`=0xBFC00000 → after one edge `id_valid`=1 and `id_pc`=0xBFC00000.
- Priority bypass: `id_inst` = `addu $3,$1,$2`; source 0 = `{1,1,0x11}`, source 1 = `{1,1,0x22}`, source 2 = `{1,2,0x33}`, `rf_rdata`=0xFF → `opnd1`=0x11, `opnd2`=0x33.
- $0 guard: rs=0 with source 0 = `{1,0,0xDEAD}` → `opnd1`=0.
- Load-use: rt=5, source 0 = `{1,5,x}` with `fwd_is_load[0]`=1 → `stallreq`=1. Hold for 3 cycles → `stall_cnt`=3. Drop `is_load` → `stallreq`=0. A shadowed case (source 0 non-load on $5, source 1 load on $5) → `stallreq`=0.
- Delay slot: `beq` in ID advances; next cycle holds a bubble (`stall[1]`=1, `stall[2]`=0); then `ori` arrives → `in_delayslot`=0 during the bubble and 1 for `ori`. A flush between the branch and `ori` gives `in_delayslot`=0.
- Counter saturation with CNT_W=4: 20 consecutive `stallreq` cycles → `stall_cnt`=15.
